ntp_sync_ctrl: RTL and testbench

Time-synchronisation sequencer that sits in front of the ntp_clock display datapath. It takes the 32-bit Unix-seconds value published by the HPS and reduces it to seconds-of-day. It aligns the load to the GPIO PPS (pulse-per-second) edge, then drives the clock's load strobe and its 1 s tick. With no PPS present it free-runs in holdover.

---
 rtl/ntp_sync_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ntp_sync_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntp_sync_ctrl.sv
// Time-sync sequencer: reduces HPS Unix seconds to seconds-of-day, aligns the load to PPS, then ticks.
// Latency: strobe to ARMED 18 cycles; PPS pin to time_load/tick_1s is 3 clk edges; all outputs registered.
// Backpressure: none; strobe/PPS inputs are always accepted, and a new hps_time_valid overrides all activity.
//
// Ports:
//   clk_i             system clock
//   reset_i           synchronous active-high reset
//   hps_time_i        Unix seconds published by the HPS
//   hps_time_valid_i  one-cycle strobe qualifying hps_time_i
//   pps_in_i          asynchronous PPS from GPIO (rising edge = second boundary)
//   time_load_o       one-cycle strobe: display clock loads time_value_o
//   time_value_o      seconds-of-day to load (0..86399)
//   tick_1s_o         one-cycle strobe: display clock advances one second
//   sync_state_o      0 IDLE, 1 ARMED/CONVERT, 2 LOCKED, 3 HOLDOVER
//   miss_cnt_o        missed PPS count, saturating at 255
module ntp_sync_ctrl #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int PPS_TOL     = 50_000,
    parameter int TZ_OFFSET_S = 0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] hps_time_i,
    input  logic        hps_time_valid_i,
    input  logic        pps_in_i,
    output logic        time_load_o,
    output logic [16:0] time_value_o,
    output logic        tick_1s_o,
    output logic [1:0]  sync_state_o,
    output logic [7:0]  miss_cnt_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int SEC_MAX = CLK_HZ + PPS_TOL - 1;
    localparam int CW      = $clog2(SEC_MAX + 1);

    localparam logic [CW-1:0] SEC_NOM_C = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0] SEC_MAX_C = CW'(SEC_MAX);
    localparam logic [CW-1:0] ACC_LO_C  = CW'(CLK_HZ - PPS_TOL);
    localparam logic [CW-1:0] TOL_C     = CW'(PPS_TOL);
    localparam logic [CW-1:0] ONE_C     = CW'(1);

    localparam logic [31:0] DAY_32   = 32'd86400;
    localparam logic [17:0] DAY_18   = 18'd86400;
    localparam logic [16:0] DAY_M1   = 17'd86399;
    localparam logic [17:0] TZ_18    = 18'(TZ_OFFSET_S);

    // Step counter values inside CONVERT: 0..15 reduction, 16 offset, 17 hand-off.
    localparam logic [4:0] STEP_TOD  = 5'd16;
    localparam logic [4:0] STEP_LAST = 5'd17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_ARMED,
        ST_LOCKED,
        ST_HOLD
    } state_e;

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_e         state_q, state_d;
    logic [CW-1:0]  sec_cnt_q, sec_cnt_d;
    logic [31:0]    rem_q, rem_d;
    logic [4:0]     step_q, step_d;
    logic [16:0]    tod_q, tod_d;
    logic           time_load_q, time_load_d;
    logic           tick_q, tick_d;
    logic [16:0]    time_value_q, time_value_d;
    logic [1:0]     sync_state_q, sync_state_d;
    logic [7:0]     miss_q, miss_d;

    logic           pps_s1_q, pps_s2_q, pps_s3_q;

    // ------------------------------------------------------------------
    // PPS synchroniser and edge detect. pps_edge is combinational off the
    // second sync stage so the FSM acts on the third edge after the pin rises.
    // ------------------------------------------------------------------
    logic pps_edge;
    assign pps_edge = pps_s2_q & ~pps_s3_q;

    // Window qualifiers on the free-running second counter.
    logic sec_at_nom, sec_at_max, pps_ok, pps_early;
    assign sec_at_nom = (sec_cnt_q == SEC_NOM_C);
    assign sec_at_max = (sec_cnt_q == SEC_MAX_C);
    assign pps_ok     = pps_edge & (sec_cnt_q >= ACC_LO_C);
    // An edge shortly after a holdover tick means the tick already covered it.
    assign pps_early  = pps_edge & (sec_cnt_q < TOL_C);

    // ------------------------------------------------------------------
    // Day-reduction datapath
    // ------------------------------------------------------------------
    logic [3:0]  shamt;
    logic [31:0] sub_val;
    logic [17:0] tod_sum;

    assign shamt   = 4'd15 - step_q[3:0];
    assign sub_val = DAY_32 << shamt;             // 86400<<15 still fits in 32 bits
    assign tod_sum = {1'b0, rem_q[16:0]} + TZ_18; // rem < 86400 once reduced

    // ------------------------------------------------------------------
    // Process 1: state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            sec_cnt_q    <= '0;
            rem_q        <= '0;
            step_q       <= '0;
            tod_q        <= '0;
            time_load_q  <= 1'b0;
            tick_q       <= 1'b0;
            time_value_q <= '0;
            sync_state_q <= 2'd0;
            miss_q       <= '0;
            pps_s1_q     <= 1'b0;
            pps_s2_q     <= 1'b0;
            pps_s3_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
            rem_q        <= rem_d;
            step_q       <= step_d;
            tod_q        <= tod_d;
            time_load_q  <= time_load_d;
            tick_q       <= tick_d;
            time_value_q <= time_value_d;
            sync_state_q <= sync_state_d;
            miss_q       <= miss_d;
            pps_s1_q     <= pps_in_i;
            pps_s2_q     <= pps_s1_q;
            pps_s3_q     <= pps_s2_q;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (hps_time_valid_i) begin
            // A fresh HPS time always restarts the sequence.
            state_d = ST_CONVERT;
        end else begin
            unique case (state_q)
                ST_IDLE:    state_d = ST_IDLE;
                ST_CONVERT: if (step_q == STEP_LAST) state_d = ST_ARMED;
                ST_ARMED: begin
                    if (pps_edge)        state_d = ST_LOCKED;
                    else if (sec_at_nom) state_d = ST_HOLD;
                end
                ST_LOCKED: begin
                    if (pps_ok)          state_d = ST_LOCKED;
                    else if (sec_at_max) state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (pps_ok || pps_early) state_d = ST_LOCKED;
                end
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Process 3: output and datapath next values (registered above)
    // ------------------------------------------------------------------
    always_comb begin
        sec_cnt_d    = sec_cnt_q;
        rem_d        = rem_q;
        step_d       = step_q;
        tod_d        = tod_q;
        time_load_d  = 1'b0;
        tick_d       = 1'b0;
        time_value_d = time_value_q;
        miss_d       = miss_q;

        if (hps_time_valid_i) begin
            rem_d     = hps_time_i;
            step_d    = '0;
            miss_d    = '0;
            sec_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    sec_cnt_d = '0;
                end

                ST_CONVERT: begin
                    sec_cnt_d = '0;
                    step_d    = step_q + 5'd1;
                    if (step_q < STEP_TOD) begin
                        // Restoring division by 86400, quotient discarded.
                        if (rem_q >= sub_val) begin
                            rem_d = rem_q - sub_val;
                        end
                    end else if (step_q == STEP_TOD) begin
                        if (tod_sum >= DAY_18) begin
                            tod_d = 17'(tod_sum - DAY_18);
                        end else begin
                            tod_d = tod_sum[16:0];
                        end
                    end
                end

                ST_ARMED: begin
                    if (pps_edge || sec_at_nom) begin
                        // Load the second that is about to start.
                        time_load_d  = 1'b1;
                        time_value_d = (tod_q == DAY_M1) ? '0 : tod_q + 17'd1;
                        sec_cnt_d    = '0;
                    end else begin
                        sec_cnt_d = sec_cnt_q + ONE_C;
                    end
                end

                ST_LOCKED: begin
                    if (pps_ok) begin
                        tick_d    = 1'b1;
                        sec_cnt_d = '0;
                    end else if (sec_at_max) begin
                        // Late tick; restart at PPS_TOL so holdover keeps the nominal phase.
                        tick_d    = 1'b1;
                        miss_d    = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
                        sec_cnt_d = TOL_C;
                    end else begin
                        // Early edges are glitches: counting continues undisturbed.
                        sec_cnt_d = sec_cnt_q + ONE_C;
                    end
                end

                ST_HOLD: begin
                    if (pps_ok) begin
                        tick_d    = 1'b1;
                        sec_cnt_d = '0;
                    end else if (pps_early) begin
                        sec_cnt_d = '0;
                    end else if (sec_at_nom) begin
                        tick_d    = 1'b1;
                        sec_cnt_d = '0;
                    end else begin
                        sec_cnt_d = sec_cnt_q + ONE_C;
                    end
                end

                default: begin
                    sec_cnt_d = '0;
                end
            endcase
        end
    end

    // Reported state follows the next state so it lines up with the strobes.
    always_comb begin
        sync_state_d = 2'd0;
        unique case (state_d)
            ST_IDLE:    sync_state_d = 2'd0;
            ST_CONVERT: sync_state_d = 2'd1;
            ST_ARMED:   sync_state_d = 2'd1;
            ST_LOCKED:  sync_state_d = 2'd2;
            ST_HOLD:    sync_state_d = 2'd3;
            default:    sync_state_d = 2'd0;
        endcase
    end

    assign time_load_o  = time_load_q;
    assign time_value_o = time_value_q;
    assign tick_1s_o    = tick_q;
    assign sync_state_o = sync_state_q;
    assign miss_cnt_o   = miss_q;

endmodule

// File: tb/tb_ntp_sync_ctrl.sv
// Directed bench for ntp_sync_ctrl with an event scoreboard on time_load/tick_1s.
// Cycle n means the state observed at the falling edge after the n-th rising edge.
// A second instance with a timezone offset covers the offset path.
module tb_ntp_sync_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] hps_time;
    logic        hps_time_valid;
    logic        tz_valid;
    logic        pps_in;

    logic        time_load, tick_1s;
    logic [16:0] time_value;
    logic [1:0]  sync_state;
    logic [7:0]  miss_cnt;

    logic        tz_time_load, tz_tick_1s;
    logic [16:0] tz_time_value;
    logic [1:0]  tz_sync_state;
    logic [7:0]  tz_miss_cnt;

    ntp_sync_ctrl #(.CLK_HZ(1000), .PPS_TOL(50), .TZ_OFFSET_S(0)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .hps_time_i       (hps_time),
        .hps_time_valid_i (hps_time_valid),
        .pps_in_i         (pps_in),
        .time_load_o      (time_load),
        .time_value_o     (time_value),
        .tick_1s_o        (tick_1s),
        .sync_state_o     (sync_state),
        .miss_cnt_o       (miss_cnt)
    );

    ntp_sync_ctrl #(.CLK_HZ(1000), .PPS_TOL(50), .TZ_OFFSET_S(3600)) dut_tz (
        .clk_i            (clk),
        .reset_i          (reset),
        .hps_time_i       (hps_time),
        .hps_time_valid_i (tz_valid),
        .pps_in_i         (pps_in),
        .time_load_o      (tz_time_load),
        .time_value_o     (tz_time_value),
        .tick_1s_o        (tz_tick_1s),
        .sync_state_o     (tz_sync_state),
        .miss_cnt_o       (tz_miss_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        bit          is_tick;
        int          at;
        logic [16:0] val;
    } ev_t;

    ev_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic expect_ev(input bit is_tick, input int at, input logic [16:0] val);
        ev_t e;
        e.is_tick = is_tick;
        e.at      = at;
        e.val     = val;
        exp_q.push_back(e);
    endtask

    // One clock; then compare any strobe against the scoreboard head.
    task automatic cyc1();
        ev_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            chk("missed_event_cycle", cyc, exp_q[0].at);
            void'(exp_q.pop_front());
        end
        if (time_load || tick_1s) begin
            if (exp_q.size() == 0) begin
                chk("spurious_event", {30'd0, tick_1s, time_load}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ev_tick",  tick_1s,   e.is_tick);
                chk("ev_load",  time_load, !e.is_tick);
                chk("ev_cycle", cyc,       e.at);
                if (!e.is_tick) chk("load_value", time_value, e.val);
            end
        end
    endtask

    task automatic run_until(input int t);
        while (cyc < t) cyc1();
    endtask

    // Raise the pin so the FSM sees the edge on rising edge t.
    task automatic pps_rise_for(input int t);
        run_until(t - 3);
        pps_in = 1'b1;
        run_until(t + 5);
        pps_in = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] val);
        hps_time       = val;
        hps_time_valid = 1'b1;
        cyc1();
        hps_time_valid = 1'b0;
    endtask

    int s, e1, e2, e3, t6;

    initial begin
        reset          = 1'b1;
        hps_time       = '0;
        hps_time_valid = 1'b0;
        tz_valid       = 1'b0;
        pps_in         = 1'b0;

        // Reset state
        repeat (3) cyc1();
        reset = 1'b0;
        cyc1();
        chk("rst_time_load",  time_load,  0);
        chk("rst_tick",       tick_1s,    0);
        chk("rst_time_value", time_value, 0);
        chk("rst_state",      sync_state, 0);
        chk("rst_miss",       miss_cnt,   0);

        // Reset mid-CONVERT discards the conversion
        strobe(32'd262800);
        repeat (5) cyc1();
        chk("mid_convert_state", sync_state, 1);
        reset = 1'b1;
        cyc1();
        cyc1();
        reset = 1'b0;
        chk("rst2_time_load",  time_load,  0);
        chk("rst2_tick",       tick_1s,    0);
        chk("rst2_time_value", time_value, 0);
        chk("rst2_state",      sync_state, 0);
        chk("rst2_miss",       miss_cnt,   0);
        run_until(cyc + 1100);
        chk("idle_after_rst", sync_state, 0);

        // 262800 = 3 days + 3600 s; PPS pin at cycle 100 loads 3601 at 103
        strobe(32'd262800);
        s = cyc;
        chk("convert_state0", sync_state, 1);
        run_until(s + 17);
        chk("convert_state17", sync_state, 1);
        run_until(s + 18);
        chk("armed_state", sync_state, 1);
        expect_ev(1'b0, s + 103, 17'd3601);
        pps_rise_for(s + 103);
        e1 = s + 103;
        chk("locked_state", sync_state, 2);
        chk("locked_miss",  miss_cnt,   0);

        // Glitch at sec_cnt 300 ignored; genuine edge at sec_cnt 999 ticks once
        pps_rise_for(e1 + 301);
        chk("glitch_state", sync_state, 2);
        expect_ev(1'b1, e1 + 1000, '0);
        pps_rise_for(e1 + 1000);
        e2 = e1 + 1000;
        chk("genuine_state", sync_state, 2);

        // PPS lost: late tick when sec_cnt reaches 1049 (edge e2+1050),
        // then holdover ticks on the nominal grid, PPS returns at sec_cnt 980.
        expect_ev(1'b1, e2 + 1050, '0);
        run_until(e2 + 1050);
        chk("miss_state", sync_state, 3);
        chk("miss_count", miss_cnt,   1);
        expect_ev(1'b1, e2 + 2000, '0);
        expect_ev(1'b1, e2 + 3000, '0);
        expect_ev(1'b1, e2 + 3981, '0);
        pps_rise_for(e2 + 3981);
        e3 = e2 + 3981;
        chk("relock_state", sync_state, 2);
        chk("relock_miss",  miss_cnt,   1);

        // Strobe coincident with an accepted edge: strobe wins, miss_cnt cleared
        t6 = e3 + 1000;
        run_until(t6 - 3);
        pps_in = 1'b1;
        run_until(t6 - 1);
        hps_time       = 32'd86399;
        hps_time_valid = 1'b1;
        tz_valid       = 1'b1;
        cyc1();
        hps_time_valid = 1'b0;
        tz_valid       = 1'b0;
        chk("coincide_state", sync_state, 1);
        chk("coincide_miss",  miss_cnt,   0);
        run_until(t6 + 5);
        pps_in = 1'b0;

        // No PPS: timeout load 18+1000 cycles after strobe; 86399 wraps to 0,
        // and with a 3600 s offset 86399 -> 3599 -> loads 3600.
        expect_ev(1'b0, t6 + 1018, 17'd0);
        run_until(t6 + 1018);
        chk("tz_load",  tz_time_load,  1);
        chk("tz_value", tz_time_value, 3600);
        chk("tz_tick",  tz_tick_1s,    0);
        chk("tz_miss",  tz_miss_cnt,   0);
        cyc1();
        chk("timeout_state",    sync_state,    3);
        chk("tz_timeout_state", tz_sync_state, 3);
        chk("wrap_value_held",  time_value,    0);

        // Holdover tick, then an edge at sec_cnt 20 relocks without a tick
        expect_ev(1'b1, t6 + 2018, '0);
        pps_rise_for(t6 + 2039);
        chk("early_relock_state", sync_state, 2);
        chk("early_relock_miss",  miss_cnt,   0);

        run_until(cyc + 10);
        chk("pending_events", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
